// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared FSM state type and slice width for the serial add/sub controller
package alu_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int SLICE_W = 4;
endpackage

// File: rtl/nibble_add4.sv
// nibble_add4: plain 4-bit adder slice (a, b, cin in; sum, cout out)
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: nibble-serial add/sub (i_clk, i_rst, i_start/i_sub/i_a/i_b in; o_busy, o_done, o_result, o_carry, o_overflow out)
module serial_addsub_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NSLICE = WIDTH / SLICE_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow
);
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, sub_q, sub_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [SLICE_W-1:0] sum;
  logic cout, last;
  nibble_add4 u_add (
    .a   (a_q[SLICE_W*idx_q +: SLICE_W]),
    .b   (b_q[SLICE_W*idx_q +: SLICE_W]),
    .cin (carry_q),
    .sum (sum),
    .cout(cout)
  );
  assign last = idx_q == IW'(NSLICE - 1);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    if (state_q == IDLE && i_start) begin
      state_d = RUN;
      idx_d   = '0;
      carry_d = i_sub;
      sub_d   = i_sub;
      a_d     = i_a;
      b_d     = i_sub ? ~i_b : i_b;
      res_d   = '0;
    end else if (state_q == RUN) begin
      res_d[SLICE_W*idx_q +: SLICE_W] = sum;
      carry_d = cout;
      idx_d   = last ? idx_q : idx_q + 1'b1;
      state_d = last ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end
  assign o_busy     = state_q != IDLE;
  assign o_done     = state_q == DONE;
  assign o_result   = res_q;
  assign o_carry    = carry_q ^ sub_q;
  assign o_overflow = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_q[WIDTH-1] != a_q[WIDTH-1]);
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb_serial_addsub_ctrl: scoreboard bench with a plain-arithmetic reference model
module tb_serial_addsub_ctrl;
  localparam int W  = 16;
  localparam int NS = W / 4;
  logic i_clk = 1'b0;
  logic i_rst, i_start, i_sub;
  logic [W-1:0] i_a, i_b, o_result;
  logic o_busy, o_done, o_carry, o_overflow;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         ov;
    int           t;
  } exp_t;
  exp_t q[$];
  exp_t mon_e, last;
  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_sub(i_sub),
    .i_a(i_a), .i_b(i_b), .o_busy(o_busy), .o_done(o_done),
    .o_result(o_result), .o_carry(o_carry), .o_overflow(o_overflow)
  );
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int sa, sb, r;
    logic [W:0] full;
    full = s ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = s ? sa - sb : sa + sb;
    e.res = full[W-1:0];
    e.c   = full[W];
    e.ov  = (r > 32767) || (r < -32768);
    e.t   = cyc;
    q.push_back(e);
  endtask
  always @(negedge i_clk) begin
    if (o_done) begin
      if (q.size() == 0) chk("spurious_done", 32'(o_done), 32'd0);
      else begin
        mon_e = q.pop_front();
        chk("result", 32'(o_result), 32'(mon_e.res));
        chk("carry", 32'(o_carry), 32'(mon_e.c));
        chk("overflow", 32'(o_overflow), 32'(mon_e.ov));
        chk("latency", 32'(cyc), 32'(mon_e.t + NS));
        last = mon_e;
      end
    end else if (q.size() > 0 && cyc > q[0].t + NS) begin
      chk("done_missing", 32'(o_done), 32'd1);
      void'(q.pop_front());
    end
  end
  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 50) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (o_busy) chk("idle_timeout", 32'(o_busy), 32'd0);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 50) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    wait_idle();
    i_a = a; i_b = b; i_sub = s; i_start = 1'b1;
    @(posedge i_clk); #1;
    push(a, b, s);
    i_start = 1'b0;
    i_a = W'($urandom);
    i_b = W'($urandom);
    i_sub = 1'($urandom);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_done"}, 32'(o_done), 32'd0);
    chk({tag, "_result"}, 32'(o_result), 32'd0);
    chk({tag, "_carry"}, 32'(o_carry), 32'd0);
    chk({tag, "_overflow"}, 32'(o_overflow), 32'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    i_rst = 1'b1; i_start = 1'b0; i_sub = 1'b0; i_a = '0; i_b = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk_zero("reset");
    i_rst = 1'b0;
    op(16'h1234, 16'h0FCC, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0);
    op(16'h0005, 16'h0007, 1'b1);
    op(16'h0000, 16'h0000, 1'b1);
    op(16'h8000, 16'h0001, 1'b1);
    drain();
    repeat (3) @(posedge i_clk);
    #1;
    chk("hold_result", 32'(o_result), 32'(last.res));
    chk("hold_carry", 32'(o_carry), 32'(last.c));
    chk("hold_overflow", 32'(o_overflow), 32'(last.ov));
    wait_idle();
    i_a = 16'h1111; i_b = 16'h2222; i_sub = 1'b0; i_start = 1'b1;
    @(posedge i_clk); #1;
    push(16'h1111, 16'h2222, 1'b0);
    i_a = 16'hAAAA; i_b = 16'h5555; i_sub = 1'b1;
    n = 0;
    while (!o_done && n < 20) begin
      @(posedge i_clk); #1;
      n++;
    end
    @(posedge i_clk); #1;
    chk("idle_after_done", 32'(o_busy), 32'd0);
    @(posedge i_clk); #1;
    push(16'hAAAA, 16'h5555, 1'b1);
    i_start = 1'b0;
    chk("b2b_accept", 32'(o_busy), 32'd1);
    drain();
    wait_idle();
    i_a = 16'h4321; i_b = 16'h1234; i_sub = 1'b0; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    @(posedge i_clk); #1;
    i_rst = 1'b1; i_start = 1'b1;
    @(posedge i_clk); #1;
    chk_zero("abort");
    @(posedge i_clk); #1;
    chk("rst_over_start", 32'(o_busy), 32'd0);
    i_rst = 1'b0; i_start = 1'b0;
    repeat (8) @(posedge i_clk);
    #1;
    op(16'h0F0F, 16'hF0F1, 1'b0);
    for (int i = 0; i < 40; i++) op(W'($urandom), W'($urandom), 1'($urandom));
    drain();
    repeat (2) @(posedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
